// File: rtl/uc_pkg.sv
// ----------------------------------------------------------------------------
// uc_pkg
// Shared definitions for the unidad_control main decoder:
//   - RV32I-subset opcode constants
//   - writeback (reg_sel), immediate format (ext_sel), ALU operand source
//     (alu_src) and ALU operation (alu_sel) encodings
//   - ALU decode class used between the top decoder and uc_alu_decode
//   - ctrl_t: the full bundle of datapath controls, zero == NOP
// ----------------------------------------------------------------------------
package uc_pkg;

  // Opcodes (instr[6:0])
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // funct7 values that matter
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Writeback source
  localparam logic [1:0] RS_ALU  = 2'b00;
  localparam logic [1:0] RS_DMEM = 2'b01;
  localparam logic [1:0] RS_PC4  = 2'b10;
  localparam logic [1:0] RS_IMM  = 2'b11;

  // Immediate format
  localparam logic [3:0] EXT_NONE = 4'b0000;
  localparam logic [3:0] EXT_I    = 4'b0001;
  localparam logic [3:0] EXT_S    = 4'b0010;
  localparam logic [3:0] EXT_B    = 4'b0011;
  localparam logic [3:0] EXT_U    = 4'b0100;
  localparam logic [3:0] EXT_J    = 4'b0101;

  // ALU operand select: bit0 picks B (rs2/imm), bit1 picks A (rs1/PC)
  localparam logic [1:0] SRC_REG = 2'b00;
  localparam logic [1:0] SRC_IMM = 2'b01;

  // ALU operation
  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_OR   = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_SLL  = 4'h5;
  localparam logic [3:0] ALU_SRL  = 4'h6;
  localparam logic [3:0] ALU_SRA  = 4'h7;
  localparam logic [3:0] ALU_SLT  = 4'h8;
  localparam logic [3:0] ALU_SLTU = 4'h9;
  localparam logic [3:0] ALU_EQ   = 4'hA;
  localparam logic [3:0] ALU_NE   = 4'hB;

  // How uc_alu_decode should interpret funct3/funct7
  typedef enum logic [1:0] {
    CLS_NONE   = 2'd0,  // fixed ADD (address / link computations)
    CLS_R      = 2'd1,  // register-register ALU
    CLS_I      = 2'd2,  // register-immediate ALU
    CLS_BRANCH = 2'd3   // compare for branch
  } alu_class_e;

  typedef struct packed {
    logic       jal_sel;
    logic       j_sel;
    logic [1:0] reg_sel;
    logic       ws_en;
    logic       w_en;
    logic [3:0] ext_sel;
    logic [1:0] alu_src;
    logic [3:0] alu_sel;
    logic       width;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // funct3 -> ALU op for the arithmetic group with funct7 = 0000000.
  function automatic logic [3:0] base_alu_op(input logic [2:0] f3);
    logic [3:0] op;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/uc_alu_decode.sv
// ----------------------------------------------------------------------------
// uc_alu_decode
// Combinational ALU-operation decode. Given the instruction class chosen by
// the main decoder plus funct3/funct7, produces the ALU operation and whether
// the funct3/funct7 combination is a supported encoding for that class.
// Ports:
//   cls_i     in  alu_class_e  instruction class
//   funct3_i  in  3            instr[14:12]
//   funct7_i  in  7            instr[31:25]
//   alu_sel_o out 4            ALU operation
//   valid_o   out 1            encoding supported for this class
// ----------------------------------------------------------------------------
module uc_alu_decode
  import uc_pkg::*;
(
  input  alu_class_e  cls_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  output logic [3:0]  alu_sel_o,
  output logic        valid_o
);

  logic f7_base;
  logic f7_alt;
  logic is_shift;

  assign f7_base  = (funct7_i == F7_BASE);
  assign f7_alt   = (funct7_i == F7_ALT);
  // funct3 001/101 are the shift group; only these look at funct7 on OP-IMM
  assign is_shift = (funct3_i[1:0] == 2'b01);

  always_comb begin
    alu_sel_o = ALU_ADD;
    valid_o   = 1'b0;
    case (cls_i)
      CLS_NONE: begin
        alu_sel_o = ALU_ADD;
        valid_o   = 1'b1;
      end
      CLS_R: begin
        if (f7_base) begin
          alu_sel_o = base_alu_op(funct3_i);
          valid_o   = 1'b1;
        end else if (f7_alt) begin
          if (funct3_i == 3'b000) begin
            alu_sel_o = ALU_SUB;
            valid_o   = 1'b1;
          end else if (funct3_i == 3'b101) begin
            alu_sel_o = ALU_SRA;
            valid_o   = 1'b1;
          end
        end
      end
      CLS_I: begin
        if (!is_shift) begin
          // No SUBI: funct3 000 is always ADDI whatever funct7 holds
          alu_sel_o = base_alu_op(funct3_i);
          valid_o   = 1'b1;
        end else if (f7_base) begin
          alu_sel_o = base_alu_op(funct3_i);
          valid_o   = 1'b1;
        end else if (f7_alt && (funct3_i == 3'b101)) begin
          alu_sel_o = ALU_SRA;
          valid_o   = 1'b1;
        end
      end
      CLS_BRANCH: begin
        if (funct3_i == 3'b000) begin
          alu_sel_o = ALU_EQ;
          valid_o   = 1'b1;
        end else if (funct3_i == 3'b001) begin
          alu_sel_o = ALU_NE;
          valid_o   = 1'b1;
        end
      end
      default: begin
        alu_sel_o = ALU_ADD;
        valid_o   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/unidad_control.sv
// ----------------------------------------------------------------------------
// unidad_control
// Main decoder of the single-issue RV32I-subset core. Decodes opcode/funct3/
// funct7 into datapath controls and registers them, so every output appears
// one cycle after its inputs (aligned with execute). rst_n low forces NOP
// (all outputs 0) immediately.
// Ports:
//   clk      in   1  clock, rising edge
//   rst_n    in   1  asynchronous active-low reset
//   opcode   in   7  instr[6:0]
//   funct3   in   3  instr[14:12]
//   funct7   in   7  instr[31:25]
//   jal_sel  out  1  PC target: 1 PC+imm, 0 ALU result (JALR)
//   j_sel    out  1  unconditional jump
//   reg_sel  out  2  writeback source: 00 ALU, 01 DMEM, 10 PC+4, 11 IMM
//   ws_en    out  1  data-memory write enable
//   w_en     out  1  register-file write enable
//   ext_sel  out  4  immediate format
//   alu_src  out  2  [0] B operand: rs2/imm, [1] A operand: rs1/PC
//   alu_sel  out  4  ALU operation
//   width    out  1  memory width: 1 word, 0 byte
//   illegal  out  1  only with UC_ILLEGAL_EN: encoding decoded as NOP
//                    (opcode 0 excluded)
// Configuration macro: UC_ILLEGAL_EN
// ----------------------------------------------------------------------------
module unidad_control
  import uc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic       jal_sel,
  output logic       j_sel,
  output logic [1:0] reg_sel,
  output logic       ws_en,
  output logic       w_en,
  output logic [3:0] ext_sel,
  output logic [1:0] alu_src,
  output logic [3:0] alu_sel,
  output logic       width
`ifdef UC_ILLEGAL_EN
  ,
  output logic       illegal
`endif
);

  alu_class_e alu_cls;
  logic [3:0] alu_op;
  logic       alu_ok;
  ctrl_t      ctrl_dec;
  logic       dec_ok;
  ctrl_t      ctrl_d;
  ctrl_t      ctrl_q;

  // Class selection kept apart from the main case so the ALU decode sits
  // strictly between opcode and the main decode (no combinational feedback).
  always_comb begin
    case (opcode)
      OP_R:      alu_cls = CLS_R;
      OP_IMM:    alu_cls = CLS_I;
      OP_BRANCH: alu_cls = CLS_BRANCH;
      default:   alu_cls = CLS_NONE;
    endcase
  end

  uc_alu_decode u_alu_decode (
    .cls_i     (alu_cls),
    .funct3_i  (funct3),
    .funct7_i  (funct7),
    .alu_sel_o (alu_op),
    .valid_o   (alu_ok)
  );

  // Main decode. Fields are filled in freely; dec_ok gates the whole bundle
  // to NOP so partially-set fields of a rejected encoding never escape.
  always_comb begin
    ctrl_dec       = CTRL_NOP;
    dec_ok         = 1'b0;
    ctrl_dec.width = 1'b1;
    case (opcode)
      OP_LOAD: begin
        ctrl_dec.w_en    = 1'b1;
        ctrl_dec.reg_sel = RS_DMEM;
        ctrl_dec.ext_sel = EXT_I;
        ctrl_dec.alu_src = SRC_IMM;
        ctrl_dec.alu_sel = ALU_ADD;
        ctrl_dec.width   = (funct3 == 3'b010);
        dec_ok           = (funct3 == 3'b010) || (funct3 == 3'b100);
      end
      OP_STORE: begin
        ctrl_dec.ws_en   = 1'b1;
        ctrl_dec.ext_sel = EXT_S;
        ctrl_dec.alu_src = SRC_IMM;
        ctrl_dec.alu_sel = ALU_ADD;
        ctrl_dec.width   = (funct3 == 3'b010);
        dec_ok           = (funct3 == 3'b010) || (funct3 == 3'b000);
      end
      OP_R: begin
        ctrl_dec.w_en    = 1'b1;
        ctrl_dec.reg_sel = RS_ALU;
        ctrl_dec.alu_src = SRC_REG;
        ctrl_dec.alu_sel = alu_op;
        dec_ok           = alu_ok;
      end
      OP_IMM: begin
        ctrl_dec.w_en    = 1'b1;
        ctrl_dec.reg_sel = RS_ALU;
        ctrl_dec.ext_sel = EXT_I;
        ctrl_dec.alu_src = SRC_IMM;
        ctrl_dec.alu_sel = alu_op;
        dec_ok           = alu_ok;
      end
      OP_BRANCH: begin
        // Datapath branches when ext_sel==B and the compare result bit is 1
        ctrl_dec.jal_sel = 1'b1;
        ctrl_dec.ext_sel = EXT_B;
        ctrl_dec.alu_src = SRC_REG;
        ctrl_dec.alu_sel = alu_op;
        dec_ok           = alu_ok;
      end
      OP_JAL: begin
        ctrl_dec.j_sel   = 1'b1;
        ctrl_dec.jal_sel = 1'b1;
        ctrl_dec.w_en    = 1'b1;
        ctrl_dec.reg_sel = RS_PC4;
        ctrl_dec.ext_sel = EXT_J;
        dec_ok           = 1'b1;
      end
      OP_JALR: begin
        ctrl_dec.j_sel   = 1'b1;
        ctrl_dec.jal_sel = 1'b0;
        ctrl_dec.w_en    = 1'b1;
        ctrl_dec.reg_sel = RS_PC4;
        ctrl_dec.ext_sel = EXT_I;
        ctrl_dec.alu_src = SRC_IMM;
        ctrl_dec.alu_sel = ALU_ADD;
        dec_ok           = (funct3 == 3'b000);
      end
      OP_LUI: begin
        ctrl_dec.w_en    = 1'b1;
        ctrl_dec.reg_sel = RS_IMM;
        ctrl_dec.ext_sel = EXT_U;
        dec_ok           = 1'b1;
      end
      default: begin
        dec_ok = 1'b0;
      end
    endcase
  end

  assign ctrl_d = dec_ok ? ctrl_dec : CTRL_NOP;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= CTRL_NOP;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign jal_sel = ctrl_q.jal_sel;
  assign j_sel   = ctrl_q.j_sel;
  assign reg_sel = ctrl_q.reg_sel;
  assign ws_en   = ctrl_q.ws_en;
  assign w_en    = ctrl_q.w_en;
  assign ext_sel = ctrl_q.ext_sel;
  assign alu_src = ctrl_q.alu_src;
  assign alu_sel = ctrl_q.alu_sel;
  assign width   = ctrl_q.width;

`ifdef UC_ILLEGAL_EN
  logic illegal_d;
  logic illegal_q;

  // Opcode 0 is the all-zero bubble, not an illegal instruction
  assign illegal_d = !dec_ok && (opcode != 7'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end

  assign illegal = illegal_q;
`endif

endmodule

// File: tb/tb_unidad_control.sv
// ----------------------------------------------------------------------------
// tb_unidad_control
// Self-checking bench for unidad_control. The reference model is a table of
// legal instruction encodings (with don't-care funct3/funct7 where the
// instruction ignores them) and their control vectors; anything not in the
// table is NOP. Directed steps cover the documented cases, then randomized
// encodings, then an asynchronous reset in mid-stream.
// Control vector layout: {jal_sel, j_sel, reg_sel, ws_en, w_en, ext_sel,
// alu_src, alu_sel, width} = 17 bits.
// ----------------------------------------------------------------------------
module tb_unidad_control;

  logic       clk;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       jal_sel;
  logic       j_sel;
  logic [1:0] reg_sel;
  logic       ws_en;
  logic       w_en;
  logic [3:0] ext_sel;
  logic [1:0] alu_src;
  logic [3:0] alu_sel;
  logic       width;
  logic       illegal_obs;

  int checks = 0;
  int errors = 0;

  unidad_control dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .opcode  (opcode),
    .funct3  (funct3),
    .funct7  (funct7),
    .jal_sel (jal_sel),
    .j_sel   (j_sel),
    .reg_sel (reg_sel),
    .ws_en   (ws_en),
    .w_en    (w_en),
    .ext_sel (ext_sel),
    .alu_src (alu_src),
    .alu_sel (alu_sel),
    .width   (width)
`ifdef UC_ILLEGAL_EN
    ,
    .illegal (illegal_obs)
`endif
  );

`ifndef UC_ILLEGAL_EN
  assign illegal_obs = 1'b0;
`endif

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [16:0] obs;
  assign obs = {jal_sel, j_sel, reg_sel, ws_en, w_en, ext_sel, alu_src, alu_sel, width};

  // ---------------- reference model ----------------
  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    bit          f3_any;
    logic [6:0]  f7;
    bit          f7_any;
    logic [16:0] ctl;
  } enc_t;

  enc_t tbl[$];

  function automatic logic [16:0] mk(input logic jal, input logic j, input logic [1:0] rs,
                                     input logic ws, input logic w, input logic [3:0] ext,
                                     input logic [1:0] src, input logic [3:0] alu,
                                     input logic wid);
    return {jal, j, rs, ws, w, ext, src, alu, wid};
  endfunction

  task automatic add(input logic [6:0] op, input logic [2:0] f3, input bit f3_any,
                     input logic [6:0] f7, input bit f7_any, input logic [16:0] ctl);
    enc_t e;
    e.op = op; e.f3 = f3; e.f3_any = f3_any; e.f7 = f7; e.f7_any = f7_any; e.ctl = ctl;
    tbl.push_back(e);
  endtask

  function automatic void model(input logic [6:0] op, input logic [2:0] f3,
                                input logic [6:0] f7, output logic [16:0] ctl,
                                output logic ill);
    ctl = '0;
    ill = (op != 7'd0);
    foreach (tbl[i]) begin
      if (tbl[i].op == op && (tbl[i].f3_any || tbl[i].f3 == f3) &&
          (tbl[i].f7_any || tbl[i].f7 == f7)) begin
        ctl = tbl[i].ctl;
        ill = 1'b0;
      end
    end
  endfunction

  task automatic build_table();
    // loads / stores
    add(7'b0000011, 3'b010, 0, 7'd0, 1, mk(0,0,2'b01,0,1,4'd1,2'b01,4'h0,1));
    add(7'b0000011, 3'b100, 0, 7'd0, 1, mk(0,0,2'b01,0,1,4'd1,2'b01,4'h0,0));
    add(7'b0100011, 3'b010, 0, 7'd0, 1, mk(0,0,2'b00,1,0,4'd2,2'b01,4'h0,1));
    add(7'b0100011, 3'b000, 0, 7'd0, 1, mk(0,0,2'b00,1,0,4'd2,2'b01,4'h0,0));
    // R-type
    add(7'b0110011, 3'b000, 0, 7'h00, 0, mk(0,0,2'b00,0,1,4'd0,2'b00,4'h0,1));
    add(7'b0110011, 3'b001, 0, 7'h00, 0, mk(0,0,2'b00,0,1,4'd0,2'b00,4'h5,1));
    add(7'b0110011, 3'b010, 0, 7'h00, 0, mk(0,0,2'b00,0,1,4'd0,2'b00,4'h8,1));
    add(7'b0110011, 3'b011, 0, 7'h00, 0, mk(0,0,2'b00,0,1,4'd0,2'b00,4'h9,1));
    add(7'b0110011, 3'b100, 0, 7'h00, 0, mk(0,0,2'b00,0,1,4'd0,2'b00,4'h4,1));
    add(7'b0110011, 3'b101, 0, 7'h00, 0, mk(0,0,2'b00,0,1,4'd0,2'b00,4'h6,1));
    add(7'b0110011, 3'b110, 0, 7'h00, 0, mk(0,0,2'b00,0,1,4'd0,2'b00,4'h3,1));
    add(7'b0110011, 3'b111, 0, 7'h00, 0, mk(0,0,2'b00,0,1,4'd0,2'b00,4'h2,1));
    add(7'b0110011, 3'b000, 0, 7'h20, 0, mk(0,0,2'b00,0,1,4'd0,2'b00,4'h1,1));
    add(7'b0110011, 3'b101, 0, 7'h20, 0, mk(0,0,2'b00,0,1,4'd0,2'b00,4'h7,1));
    // I-ALU
    add(7'b0010011, 3'b000, 0, 7'h00, 1, mk(0,0,2'b00,0,1,4'd1,2'b01,4'h0,1));
    add(7'b0010011, 3'b010, 0, 7'h00, 1, mk(0,0,2'b00,0,1,4'd1,2'b01,4'h8,1));
    add(7'b0010011, 3'b011, 0, 7'h00, 1, mk(0,0,2'b00,0,1,4'd1,2'b01,4'h9,1));
    add(7'b0010011, 3'b100, 0, 7'h00, 1, mk(0,0,2'b00,0,1,4'd1,2'b01,4'h4,1));
    add(7'b0010011, 3'b110, 0, 7'h00, 1, mk(0,0,2'b00,0,1,4'd1,2'b01,4'h3,1));
    add(7'b0010011, 3'b111, 0, 7'h00, 1, mk(0,0,2'b00,0,1,4'd1,2'b01,4'h2,1));
    add(7'b0010011, 3'b001, 0, 7'h00, 0, mk(0,0,2'b00,0,1,4'd1,2'b01,4'h5,1));
    add(7'b0010011, 3'b101, 0, 7'h00, 0, mk(0,0,2'b00,0,1,4'd1,2'b01,4'h6,1));
    add(7'b0010011, 3'b101, 0, 7'h20, 0, mk(0,0,2'b00,0,1,4'd1,2'b01,4'h7,1));
    // branches
    add(7'b1100011, 3'b000, 0, 7'h00, 1, mk(1,0,2'b00,0,0,4'd3,2'b00,4'hA,1));
    add(7'b1100011, 3'b001, 0, 7'h00, 1, mk(1,0,2'b00,0,0,4'd3,2'b00,4'hB,1));
    // jumps, LUI
    add(7'b1101111, 3'b000, 1, 7'h00, 1, mk(1,1,2'b10,0,1,4'd5,2'b00,4'h0,1));
    add(7'b1100111, 3'b000, 0, 7'h00, 1, mk(0,1,2'b10,0,1,4'd1,2'b01,4'h0,1));
    add(7'b0110111, 3'b000, 1, 7'h00, 1, mk(0,0,2'b11,0,1,4'd4,2'b00,4'h0,1));
  endtask

  // ---------------- scoreboard ----------------
  logic [16:0] exp_q[$];   // expected vector for the value currently registered
  logic        ill_q[$];

  task automatic check_vec(input string tag, input logic [16:0] o, input logic [16:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic check_ill(input string tag, input logic e);
`ifdef UC_ILLEGAL_EN
    checks++;
    assert (illegal_obs === e) else begin
      errors++;
      $error("FAIL %s illegal: observed %b expected %b", tag, illegal_obs, e);
    end
`else
    if (e === 1'bx) $display("note: %s", tag);
`endif
  endtask

  // Called just after a rising edge. Drives new inputs, verifies the outputs
  // still hold the previous decode, then verifies the new decode after the edge.
  task automatic step(input string tag, input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7);
    logic [16:0] e;
    logic        il;
    opcode = op; funct3 = f3; funct7 = f7;
    model(op, f3, f7, e, il);
    #1;
    check_vec({tag, "_hold"}, obs, exp_q[$]);
    @(posedge clk);
    #1;
    exp_q.push_back(e);
    ill_q.push_back(il);
    check_vec(tag, obs, exp_q[$]);
    check_ill(tag, ill_q[$]);
  endtask

  logic [6:0] op_pool[10];

  initial begin
    build_table();
    op_pool = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0000000, 7'b1111111};

    // ---- reset with LW on the inputs ----
    rst_n = 1'b0; opcode = 7'b0000011; funct3 = 3'b010; funct7 = 7'h20;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back('0);
    ill_q.push_back(1'b0);
    check_vec("reset", obs, '0);
    check_ill("reset", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_vec("reset_release_hold", obs, '0);
    @(posedge clk);
    #1;
    exp_q.push_back(17'b0_0_01_0_1_0001_01_0000_1);
    check_vec("first_lw", obs, exp_q[$]);

    // ---- directed ----
    step("lw_f7alt", 7'b0000011, 3'b010, 7'h20);
    step("lbu",      7'b0000011, 3'b100, 7'h20);
    step("lb_nop",   7'b0000011, 3'b000, 7'h00);
    step("sw",       7'b0100011, 3'b010, 7'h00);
    step("sb",       7'b0100011, 3'b000, 7'h00);
    step("jalr",     7'b1100111, 3'b000, 7'h00);
    step("jal",      7'b1101111, 3'b101, 7'h3c);
    step("add",      7'b0110011, 3'b000, 7'h00);
    step("sub",      7'b0110011, 3'b000, 7'h20);
    step("sra",      7'b0110011, 3'b101, 7'h20);
    step("r_bad_f7", 7'b0110011, 3'b000, 7'h01);
    step("bne",      7'b1100011, 3'b001, 7'h00);
    step("beq",      7'b1100011, 3'b000, 7'h11);
    step("blt_nop",  7'b1100011, 3'b100, 7'h00);
    step("lui",      7'b0110111, 3'b001, 7'h55);
    step("addi_f7",  7'b0010011, 3'b000, 7'h20);
    step("slli_bad", 7'b0010011, 3'b001, 7'h20);
    step("srai",     7'b0010011, 3'b101, 7'h20);
    step("op_7f",    7'b1111111, 3'b000, 7'h00);
    step("op_zero",  7'b0000000, 3'b000, 7'h00);
    step("jalr_bad", 7'b1100111, 3'b010, 7'h00);

    // ---- randomized ----
    for (int i = 0; i < 400; i++) begin
      logic [6:0] op;
      logic [6:0] f7;
      case ($urandom_range(0, 3))
        0:       op = 7'($urandom_range(0, 127));
        default: op = op_pool[$urandom_range(0, 9)];
      endcase
      case ($urandom_range(0, 2))
        0:       f7 = 7'h00;
        1:       f7 = 7'h20;
        default: f7 = 7'($urandom_range(0, 127));
      endcase
      step("rand", op, 3'($urandom_range(0, 7)), f7);
    end

    // ---- asynchronous reset mid-stream ----
    step("pre_reset_lw", 7'b0000011, 3'b010, 7'h00);
    rst_n = 1'b0;
    #1;
    exp_q.push_back('0);
    ill_q.push_back(1'b0);
    check_vec("async_reset", obs, '0);
    check_ill("async_reset", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_reset_jal", 7'b1101111, 3'b000, 7'h00);
    step("post_reset_7f",  7'b1111111, 3'b111, 7'h7f);
    step("post_reset_add", 7'b0110011, 3'b000, 7'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog: the stimulus is bounded, this only guards against a stuck run.
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
